// File: rtl/clk_switch_ctrl.sv
// Glitch-free switchover sequencer for the S_CLK mux: verifies target activity, gates, switches, ungates.
// Latency: WIN + 2*WAIT_CYC + 1 cycles from accepted req to done; req only accepted while idle, never queued.
module clk_switch_ctrl #(
  parameter int WAIT_CYC  = 8,
  parameter int WIN       = 64,
  parameter int MIN_EDGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic req_sel,
  input  logic clkout2,
  input  logic clkout3,
  output logic sel,
  output logic clk_en,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_GATE_OFF = 3'd2;
  localparam logic [2:0] S_SWITCH   = 3'd3;
  localparam logic [2:0] S_GATE_ON  = 3'd4;

  localparam int WIN_W  = $clog2(WIN);
  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);

  logic [2:0]        state_q;
  logic              target_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [EDGE_W-1:0] edge_cnt_q;
  logic [EDGE_W-1:0] edge_nxt;
  logic [2:0]        sync2_q;
  logic [2:0]        sync3_q;
  logic              rise2_q;
  logic              rise3_q;
  logic              tgt_rise;
  logic              win_last;
  logic              wait_last;

  // Candidate clocks are plain data here: two flops to settle, a third as edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync2_q <= '0;
      sync3_q <= '0;
      rise2_q <= 1'b0;
      rise3_q <= 1'b0;
    end else begin
      sync2_q <= {sync2_q[1:0], clkout2};
      sync3_q <= {sync3_q[1:0], clkout3};
      rise2_q <= sync2_q[1] & ~sync2_q[2];
      rise3_q <= sync3_q[1] & ~sync3_q[2];
    end
  end

  always_comb begin
    tgt_rise  = target_q ? rise2_q : rise3_q;
    win_last  = (win_cnt_q == WIN_W'(WIN - 1));
    wait_last = (wait_cnt_q == WAIT_W'(WAIT_CYC - 1));
    edge_nxt  = edge_cnt_q;
    if (edge_cnt_q != EDGE_W'(MIN_EDGES)) begin
      edge_nxt = edge_cnt_q + EDGE_W'(tgt_rise);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= 1'b1;
      sel        <= 1'b1;
      clk_en     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      win_cnt_q  <= '0;
      wait_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (req_sel == sel) begin
              done <= 1'b1;
            end else begin
              target_q   <= req_sel;
              busy       <= 1'b1;
              win_cnt_q  <= '0;
              edge_cnt_q <= '0;
              state_q    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          edge_cnt_q <= edge_nxt;
          win_cnt_q  <= win_cnt_q + WIN_W'(1);
          if (win_last) begin
            win_cnt_q <= '0;
            // A saturated edge count means the target met the activity threshold.
            if (edge_nxt == EDGE_W'(MIN_EDGES)) begin
              clk_en     <= 1'b0;
              wait_cnt_q <= '0;
              state_q    <= S_GATE_OFF;
            end else begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        S_GATE_OFF: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (wait_last) begin
            wait_cnt_q <= '0;
            state_q    <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          sel        <= target_q;
          wait_cnt_q <= '0;
          state_q    <= S_GATE_ON;
        end
        S_GATE_ON: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (wait_last) begin
            wait_cnt_q <= '0;
            clk_en     <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: done/err pulses are scored against a queue of expected events.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req = 1'b0;
  logic req_sel = 1'b0;
  logic run2 = 1'b1;
  logic run3 = 1'b0;
  logic man3 = 1'b0;
  logic clkout2, clkout3;
  logic sel, clk_en, busy, done, err;
  int   ph2 = 0;
  int   ph3 = 2;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;

  typedef struct {
    logic is_err;
    int   cyc;
    logic sel;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  clk_switch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel),
    .clkout2(clkout2), .clkout3(clkout3),
    .sel(sel), .clk_en(clk_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate clocks: period 6 clk when running, otherwise clkout3 follows man3.
  initial forever begin
    @(negedge clk);
    ph2 = (ph2 == 5) ? 0 : ph2 + 1;
    ph3 = (ph3 == 5) ? 0 : ph3 + 1;
  end
  assign clkout2 = run2 ? (ph2 < 3) : 1'b0;
  assign clkout3 = run3 ? (ph3 < 3) : man3;

  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (done === 1'b1) n_done++;
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d done=%0b err=%0b, required no pulse", cyc, done, err);
      end else begin
        e = sbq.pop_front();
        if (err !== e.is_err || done !== ~e.is_err || cyc != e.cyc || sel !== e.sel) begin
          n_fail++;
          $display("FAIL scoreboard_pulse got cyc=%0d done=%0b err=%0b sel=%0b, required cyc=%0d err=%0b sel=%0b",
                   cyc, done, err, sel, e.cyc, e.is_err, e.sel);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d, required test completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic t, output int e0);
    @(negedge clk);
    req = 1'b1;
    req_sel = t;
    e0 = cyc + 1;
  endtask

  task automatic drop_req;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sbq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (busy || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout busy=%0b pending=%0d, required busy=0 pending=0", tag, busy, sbq.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk += 5;
    if (sel !== 1'b1)    begin n_fail++; $display("FAIL rst_sel got %0b required 1", sel); end
    if (clk_en !== 1'b1) begin n_fail++; $display("FAIL rst_clk_en got %0b required 1", clk_en); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy got %0b required 0", busy); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL rst_done got %0b required 0", done); end
    if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err got %0b required 0", err); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_chk += 3;
    if (sel !== 1'b1)    begin n_fail++; $display("FAIL idle_sel got %0b required 1", sel); end
    if (clk_en !== 1'b1) begin n_fail++; $display("FAIL idle_clk_en got %0b required 1", clk_en); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_busy got %0b required 0", busy); end
  endtask

  task automatic test_switch(input logic target, input string tag);
    int e0;
    int low = 0;
    logic old = ~target;
    drive_req(target, e0);
    sbq.push_back('{1'b0, e0 + 81, target});
    drop_req();
    for (int k = 0; k <= 81; k++) begin
      if (clk_en === 1'b0) low++;
      case (k)
        0:  begin n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_start got %0b required 1", tag, busy); end end
        63: begin n_chk++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL %s_en_pre got %0b required 1", tag, clk_en); end end
        64: begin n_chk++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL %s_en_fall got %0b required 0", tag, clk_en); end end
        72: begin n_chk++; if (sel !== old) begin n_fail++; $display("FAIL %s_sel_hold got %0b required %0b", tag, sel, old); end end
        73: begin n_chk++; if (sel !== target) begin n_fail++; $display("FAIL %s_sel_new got %0b required %0b", tag, sel, target); end end
        81: begin
          n_chk += 2;
          if (clk_en !== 1'b1) begin n_fail++; $display("FAIL %s_en_rise got %0b required 1", tag, clk_en); end
          if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end got %0b required 0", tag, busy); end
        end
        default: ;
      endcase
      if (k < 81) @(negedge clk);
    end
    n_chk++;
    if (low != 17) begin n_fail++; $display("FAIL %s_gate_len got %0d required 17", tag, low); end
    wait_idle(tag);
  endtask

  task automatic test_good_switch;
    run3 = 1'b1;
    repeat (12) @(negedge clk);
    test_switch(1'b0, "to_clk3");
    test_switch(1'b1, "to_clk2");
  endtask

  task automatic test_dead_target;
    int e0;
    int low = 0;
    run3 = 1'b0;
    man3 = 1'b0;
    repeat (8) @(negedge clk);
    drive_req(1'b0, e0);
    sbq.push_back('{1'b1, e0 + 64, 1'b1});
    drop_req();
    for (int k = 0; k <= 70; k++) begin
      if (clk_en !== 1'b1) low++;
      if (k == 63) begin n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dead_busy_pre got %0b required 1", busy); end end
      if (k == 64) begin n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dead_busy_end got %0b required 0", busy); end end
      @(negedge clk);
    end
    n_chk += 2;
    if (low != 0) begin n_fail++; $display("FAIL dead_en_low got %0d cycles required 0", low); end
    if (sel !== 1'b1) begin n_fail++; $display("FAIL dead_sel got %0b required 1", sel); end
    wait_idle("dead");
  endtask

  task automatic test_threshold(input int n, input logic pass, input string tag);
    int e0;
    run3 = 1'b0;
    man3 = 1'b0;
    repeat (8) @(negedge clk);
    drive_req(1'b0, e0);
    if (pass) sbq.push_back('{1'b0, e0 + 81, 1'b0});
    else      sbq.push_back('{1'b1, e0 + 64, 1'b1});
    drop_req();
    repeat (10) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      man3 = 1'b1;
      repeat (3) @(negedge clk);
      man3 = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_idle(tag);
    n_chk++;
    if (sel !== ~pass) begin n_fail++; $display("FAIL %s_sel got %0b required %0b", tag, sel, ~pass); end
  endtask

  task automatic test_reset_mid;
    int e0;
    run3 = 1'b1;
    drive_req(1'b1, e0);
    drop_req();
    while (cyc < e0 + 67) @(negedge clk);
    n_chk += 2;
    if (clk_en !== 1'b0) begin n_fail++; $display("FAIL mid_pre_en got %0b required 0", clk_en); end
    if (sel !== 1'b0) begin n_fail++; $display("FAIL mid_pre_sel got %0b required 0", sel); end
    rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (sel !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_sel got %0b required 1", sel); end
    if (clk_en !== 1'b1) begin n_fail++; $display("FAIL mid_rst_en got %0b required 1", clk_en); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_busy got %0b required 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_post_busy got %0b required 0", busy); end
    test_switch(1'b0, "after_rst");
  endtask

  task automatic test_noop_busy;
    int e0;
    int d0;
    drive_req(1'b0, e0);
    sbq.push_back('{1'b0, e0, 1'b0});
    drop_req();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL noop_busy got %0b required 0", busy); end
    repeat (3) @(negedge clk);
    d0 = n_done;
    drive_req(1'b1, e0);
    sbq.push_back('{1'b0, e0 + 81, 1'b1});
    drop_req();
    for (int k = 0; k <= 81; k++) begin
      if (k == 20 || k == 67) begin req = 1'b1; req_sel = 1'b0; end
      if (k == 21 || k == 68) req = 1'b0;
      @(negedge clk);
    end
    wait_idle("busy_ign");
    repeat (20) @(negedge clk);
    n_chk += 2;
    if (n_done - d0 != 1) begin n_fail++; $display("FAIL busy_done_count got %0d required 1", n_done - d0); end
    if (sel !== 1'b1) begin n_fail++; $display("FAIL busy_sel got %0b required 1", sel); end
  endtask

  initial begin
    test_reset();
    test_good_switch();
    test_dead_target();
    test_threshold(3, 1'b0, "thr3");
    test_threshold(4, 1'b1, "thr4");
    test_reset_mid();
    test_noop_busy();
    n_chk++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL final_pending got %0d required 0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
